// File: rtl/conv_result_streamer.sv
// Snapshots the flat convolution result on the rising edge of done and streams it
// one pixel per beat over valid/ready. Optional ReLU on the output: define RESULT_RELU_EN.
module conv_result_streamer #(
  parameter int OUT = 126,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUT*OUT*DATA_W-1:0] result,
  input  logic                      done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [IDX_W-1:0]          m_row,
  output logic [IDX_W-1:0]          m_col,
  output logic                      m_sof,
  output logic                      m_eol,
  output logic                      m_eof,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int NPIX  = OUT * OUT;
  localparam int PIX_W = $clog2(NPIX);
  localparam int SEL_W = $clog2(NPIX * DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      done_q_r;
  logic [NPIX*DATA_W-1:0]    snapshot_r;
  logic [IDX_W-1:0]          row_r;
  logic [IDX_W-1:0]          col_r;
  logic [PIX_W-1:0]          pix_r;
  logic [DATA_W-1:0]         data_r;
  logic                      busy_r;
  logic                      frame_done_r;
  logic                      overrun_r;

  logic                      start_s;
  logic                      hs_s;
  logic                      last_s;
  logic [PIX_W-1:0]          pix_next_s;
  logic [SEL_W-1:0]          sel_s;

  function automatic logic [DATA_W-1:0] relu_pix(input logic [DATA_W-1:0] p);
`ifdef RESULT_RELU_EN
    relu_pix = p[DATA_W-1] ? '0 : p;
`else
    relu_pix = p;
`endif
  endfunction

  assign start_s    = done && !done_q_r;
  assign hs_s       = m_valid && m_ready;
  assign last_s     = (pix_r == LAST_PIX);
  assign pix_next_s = pix_r + 1'b1;
  // Bit offset of the pixel that follows the current one in raster order.
  assign sel_s      = SEL_W'(pix_next_s * DATA_W);

  assign m_valid    = (state_r == ST_STREAM);
  assign m_data     = data_r;
  assign m_row      = row_r;
  assign m_col      = col_r;
  assign m_sof      = m_valid && (pix_r == '0);
  assign m_eol      = m_valid && (col_r == LAST_IDX);
  assign m_eof      = m_valid && last_s;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_STREAM;
        else         state_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (hs_s && last_s) state_s = ST_FLUSH;
        else                state_s = ST_STREAM;
      end
      ST_FLUSH: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register, snapshot capture and per-beat raster bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      done_q_r     <= 1'b0;
      snapshot_r   <= '0;
      row_r        <= '0;
      col_r        <= '0;
      pix_r        <= '0;
      data_r       <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      done_q_r     <= done;
      frame_done_r <= (state_r == ST_FLUSH);
      if (start_s && (state_r != ST_IDLE)) overrun_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            // First pixel comes straight from the bus; the snapshot is loaded on the same edge.
            snapshot_r <= result;
            row_r      <= '0;
            col_r      <= '0;
            pix_r      <= '0;
            data_r     <= relu_pix(result[DATA_W-1:0]);
            busy_r     <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (hs_s) begin
            if (last_s) begin
              busy_r <= 1'b0;
            end else begin
              data_r <= relu_pix(snapshot_r[sel_s +: DATA_W]);
              pix_r  <= pix_next_s;
              if (col_r == LAST_IDX) begin
                col_r <= '0;
                row_r <= row_r + 1'b1;
              end else begin
                col_r <= col_r + 1'b1;
              end
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed self-checking bench: a 3x3 instance for handshake/overrun/reset cases and a
// 126x126 instance for full-frame throughput.
module tb_conv_result_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3*3*16-1:0] result3 = '0;
  logic done3 = 1'b0, m_ready3 = 1'b0;
  logic m_valid3, m_sof3, m_eol3, m_eof3, busy3, frame_done3, overrun3;
  logic [15:0] m_data3;
  logic [1:0] m_row3, m_col3;

  logic [126*126*16-1:0] result126 = '0;
  logic done126 = 1'b0, m_ready126 = 1'b0;
  logic m_valid126, m_sof126, m_eol126, m_eof126, busy126, frame_done126, overrun126;
  logic [15:0] m_data126;
  logic [6:0] m_row126, m_col126;

  logic [15:0] exp3 [9];

  conv_result_streamer #(.OUT(3), .DATA_W(16)) dut3 (
    .clk(clk), .rst(rst), .result(result3), .done(done3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .m_row(m_row3), .m_col(m_col3),
    .m_sof(m_sof3), .m_eol(m_eol3), .m_eof(m_eof3),
    .busy(busy3), .frame_done(frame_done3), .overrun(overrun3)
  );

  conv_result_streamer #(.OUT(126), .DATA_W(16)) dut126 (
    .clk(clk), .rst(rst), .result(result126), .done(done126),
    .m_valid(m_valid126), .m_ready(m_ready126), .m_data(m_data126), .m_row(m_row126), .m_col(m_col126),
    .m_sof(m_sof126), .m_eol(m_eol126), .m_eof(m_eof126),
    .busy(busy126), .frame_done(frame_done126), .overrun(overrun126)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load3();
    for (int k = 0; k < 9; k++) result3[k*16 +: 16] = exp3[k];
  endtask

  // One-cycle done pulse; returns with the first beat visible.
  task automatic start3();
    done3 = 1'b1;
    step();
    done3 = 1'b0;
  endtask

  task automatic run_beats3(input int from_b, input int to_b);
    for (int b = from_b; b <= to_b; b++) begin
      check_eq("beat_valid", {31'd0, m_valid3}, 32'd1);
      check_eq("beat_data", {16'd0, m_data3}, {16'd0, exp3[b]});
      check_eq("beat_row", {30'd0, m_row3}, b / 3);
      check_eq("beat_col", {30'd0, m_col3}, b % 3);
      check_eq("beat_sof", {31'd0, m_sof3}, {31'd0, b == 0});
      check_eq("beat_eol", {31'd0, m_eol3}, {31'd0, (b % 3) == 2});
      check_eq("beat_eof", {31'd0, m_eof3}, {31'd0, b == 8});
      check_eq("beat_busy", {31'd0, busy3}, 32'd1);
      step();
    end
  endtask

  // Called right after the last handshake edge.
  task automatic finish3();
    check_eq("flush_valid", {31'd0, m_valid3}, 32'd0);
    check_eq("flush_busy", {31'd0, busy3}, 32'd0);
    check_eq("flush_fd_early", {31'd0, frame_done3}, 32'd0);
    step();
    check_eq("frame_done", {31'd0, frame_done3}, 32'd1);
    step();
    check_eq("frame_done_pulse", {31'd0, frame_done3}, 32'd0);
  endtask

  initial begin
    int cnt, cyc, beats, bad_data, bad_tag;
    logic prev_stall;
    logic [15:0] prev_data;
    logic [1:0] prev_row, prev_col;

    step();
    step();
    check_eq("rst_valid", {31'd0, m_valid3}, 32'd0);
    check_eq("rst_busy", {31'd0, busy3}, 32'd0);
    check_eq("rst_fd", {31'd0, frame_done3}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun3}, 32'd0);
    check_eq("rst_data", {16'd0, m_data3}, 32'd0);
    check_eq("rst_rowcol", {28'd0, m_row3, m_col3}, 32'd0);
    check_eq("rst_flags", {29'd0, m_sof3, m_eol3, m_eof3}, 32'd0);
    rst = 1'b0;
    step();

    // Test 1: plain frame with m_ready held high.
    for (int k = 0; k < 9; k++) exp3[k] = 16'(k + 1);
    load3();
    m_ready3 = 1'b1;
    start3();
    run_beats3(0, 8);
    finish3();

    // Test 2: m_ready pattern 1,0,0 repeating; stalled beats must hold.
    start3();
    cnt = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_row = '0;
    prev_col = '0;
    while (cnt < 9 && cyc < 60) begin
      m_ready3 = ((cyc % 3) == 0);
      if (prev_stall) begin
        check_eq("stall_data", {16'd0, m_data3}, {16'd0, prev_data});
        check_eq("stall_rowcol", {28'd0, m_row3, m_col3}, {28'd0, prev_row, prev_col});
      end
      if (m_valid3 && m_ready3) begin
        check_eq("t2_data", {16'd0, m_data3}, cnt + 1);
        check_eq("t2_rowcol", {28'd0, m_row3, m_col3}, {28'd0, 2'(cnt / 3), 2'(cnt % 3)});
        cnt++;
      end
      prev_stall = m_valid3 && !m_ready3;
      prev_data = m_data3;
      prev_row = m_row3;
      prev_col = m_col3;
      step();
      cyc++;
    end
    check_eq("t2_handshakes", cnt, 32'd9);
    m_ready3 = 1'b1;
    finish3();

    // Test 3: done rises during beat 4 with a new result; stream unchanged, overrun sticky.
    start3();
    run_beats3(0, 2);
    result3 = '1;
    done3 = 1'b1;
    run_beats3(3, 8);
    check_eq("t3_overrun", {31'd0, overrun3}, 32'd1);
    finish3();
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_held_done_idle", {31'd0, m_valid3}, 32'd0);
      step();
    end
    done3 = 1'b0;
    step();
    for (int k = 0; k < 9; k++) exp3[k] = 16'hFFFF;
    start3();
    run_beats3(0, 8);
    finish3();
    check_eq("t3_overrun_sticky", {31'd0, overrun3}, 32'd1);

    // Test 4: reset on beat 5 discards the frame.
    for (int k = 0; k < 9; k++) exp3[k] = 16'(k + 1);
    load3();
    start3();
    run_beats3(0, 3);
    check_eq("t4_beat5", {16'd0, m_data3}, 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t4_valid", {31'd0, m_valid3}, 32'd0);
    check_eq("t4_busy", {31'd0, busy3}, 32'd0);
    check_eq("t4_overrun", {31'd0, overrun3}, 32'd0);
    step();
    start3();
    run_beats3(0, 8);
    finish3();

    // Test 5: negative pixel 0; then a start in the frame_done cycle is accepted.
    exp3[0] = 16'hFFF6;
    for (int k = 1; k < 9; k++) exp3[k] = 16'd7;
    load3();
`ifdef RESULT_RELU_EN
    exp3[0] = 16'h0000;
`else
    exp3[0] = 16'hFFF6;
`endif
    start3();
    run_beats3(0, 8);
    check_eq("t5_flush_valid", {31'd0, m_valid3}, 32'd0);
    step();
    check_eq("t5_frame_done", {31'd0, frame_done3}, 32'd1);
    done3 = 1'b1;
    step();
    done3 = 1'b0;
    check_eq("t5_restart_overrun", {31'd0, overrun3}, 32'd0);
    run_beats3(0, 8);
    finish3();

    // Test 6: full 126x126 frame at one beat per cycle.
    for (int k = 0; k < 15876; k++) result126[k*16 +: 16] = 16'(k * 7 + 402);
    m_ready126 = 1'b1;
    done126 = 1'b1;
    step();
    done126 = 1'b0;
    check_eq("t6_first", {16'd0, m_data126}, 32'd402);
    check_eq("t6_sof", {31'd0, m_sof126}, 32'd1);
    cyc = 1;
    beats = 0;
    bad_data = 0;
    bad_tag = 0;
    while (!frame_done126 && cyc < 20000) begin
      if (m_valid126 && m_ready126) begin
        if (m_data126 !== 16'(beats * 7 + 402)) bad_data++;
        if (m_row126 !== 7'(beats / 126) || m_col126 !== 7'(beats % 126)) bad_tag++;
        if (beats == 15875 && m_eof126 !== 1'b1) bad_tag++;
        beats++;
      end
      step();
      cyc++;
    end
    check_eq("t6_beats", beats, 32'd15876);
    check_eq("t6_frame_done_cycle", cyc, 32'd15878);
    check_eq("t6_data_errors", bad_data, 32'd0);
    check_eq("t6_tag_errors", bad_tag, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
